// File: rtl/pg_pkg.sv
// Shared constants and helpers for the pg project's byte I/O paths.
package pg_pkg;

  localparam int BYTE_W          = 8;
  localparam int DEPTH_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;

  // Occupancy must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pg_uio_reader_if.sv
// Outbound byte stream from the UIO reader to core logic, with occupancy/status.
interface pg_uio_reader_if
  import pg_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
);

  logic [BYTE_W-1:0]       out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [cnt_w(DEPTH)-1:0] fifo_count;
  logic                    overflow;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready,
    output fifo_count,
    output overflow
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready,
    input  fifo_count,
    input  overflow
  );

endinterface

// File: rtl/pg_sync_edge.sv
// Synchronizes an async pin through STAGES flops and emits a one-cycle pulse per rising edge.
// Pulse is combinational off the last sync flop and a history flop; no backpressure.
module pg_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic pulse_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign pulse_o = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/pg_uio_reader.sv
// Strobe-qualified byte receiver feeding a FWFT FIFO; strobe-to-valid latency SYNC_STAGES+1 clocks.
// Bytes arriving while full with no pop are dropped and flagged in the sticky overflow bit.
module pg_uio_reader
  import pg_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_strobe,
  input  logic              clear,
  pg_uio_reader_if.master   out_if
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;

  logic push, pop, full, wr_en;

  pg_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .rst     (rst),
    .async_i (rx_strobe),
    .pulse_o (push)
  );

  assign full  = (count_q == CNT_W'(DEPTH));
  assign pop   = (count_q != '0) && out_if.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign wr_en = push && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (wr_en && !pop)      count_d = count_q + CNT_W'(1);
      else if (!wr_en && pop) count_d = count_q - CNT_W'(1);
      if (push && !wr_en) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en && !clear) mem_q[wr_ptr_q] <= rx_data;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_if.out_data   = mem_q[rd_ptr_q];
  assign out_if.out_valid  = (count_q != '0);
  assign out_if.fifo_count = count_q;
  assign out_if.overflow   = ovf_q;

endmodule
